// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the 16-bit WISC pipeline: owns the PC, issues one
// request at a time to instruction memory and hands fetched words to decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] instruction,
  output logic [15:0] if_pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_FULL  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        is_halt;
  logic        handshake;

  // Handshake: decode takes the word in any cycle where if_valid and id_ready
  // are both high; while if_valid is high and id_ready is low, every IF/ID
  // output holds its value.
  assign is_halt   = (instr_q[15:11] == 5'b00000);
  assign handshake = (state_q == S_FULL) && id_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      if_pc_q    <= RESET_PC;
      pc_plus2_q <= RESET_PC + 16'd2;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      if_pc_q    <= if_pc_d;
      pc_plus2_q <= pc_plus2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    if_pc_d    = if_pc_q;
    pc_plus2_d = pc_plus2_q;
    if (redirect) begin
      // A redirect wins over the handshake and over a response in the same
      // cycle; an in-flight request must be drained before fetching again.
      pc_d = redirect_pc & 16'hFFFE;
      case (state_q)
        S_FETCH: state_d = S_DRAIN;
        S_WAIT:  state_d = imem_done ? S_FETCH : S_DRAIN;
        S_DRAIN: state_d = imem_done ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_done) begin
            instr_d    = imem_rdata;
            if_pc_d    = pc_q;
            pc_plus2_d = pc_q + 16'd2;
            state_d    = S_FULL;
          end
        end
        S_FULL: begin
          if (handshake) begin
            pc_d    = pc_q + 16'd2;
            state_d = is_halt ? S_HALT : S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_done) state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // The request is gated with rst_n so nothing is issued while reset is held.
  always_comb begin
    imem_req = 1'b0;
    if_valid = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: imem_req = rst_n;
      S_FULL:  if_valid = 1'b1;
      S_HALT:  halted   = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign if_pc       = if_pc_q;
  assign pc_plus2    = pc_plus2_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for the straight-line fetch flow,
// then hand-written sequences for halt, redirects, PC wrap and mid-run reset.
module tb_fetch_unit;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_FULL  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] instruction;
  logic [15:0] if_pc;
  logic [15:0] pc_plus2;
  logic        halted;
  logic [2:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_done(imem_done),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid),
    .instruction(instruction), .if_pc(if_pc), .pc_plus2(pc_plus2),
    .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory model with programmable latency
  logic [15:0] mem [logic [15:0]];
  int          mem_lat = 1;
  int          cnt = 0;
  logic [15:0] lat_addr = 16'h0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0800;
  endfunction

  always @(negedge clk) begin
    imem_done  = 1'b0;
    imem_rdata = 16'h0000;
    if (!rst_n) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_done  = 1'b1;
          imem_rdata = mem_rd(lat_addr);
        end
      end
      if (imem_req) begin
        cnt      = mem_lat;
        lat_addr = imem_addr;
      end
    end
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},    {13'h0, dbg_state}, {13'h0, ST_FETCH});
    chk({tag, "_req"},      {15'h0, imem_req},  16'h0000);
    chk({tag, "_addr"},     imem_addr,          16'h0000);
    chk({tag, "_valid"},    {15'h0, if_valid},  16'h0000);
    chk({tag, "_instr"},    instruction,        16'h0800);
    chk({tag, "_if_pc"},    if_pc,              16'h0000);
    chk({tag, "_pc_plus2"}, pc_plus2,           16'h0002);
    chk({tag, "_halted"},   {15'h0, halted},    16'h0000);
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] ifpc;
    logic [15:0] pc2;
    logic        hlt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rdy, input logic req, input logic [15:0] addr,
                              input logic valid, input logic [15:0] instr,
                              input logic [15:0] ifpc, input logic [15:0] pc2,
                              input logic hlt);
    vec_t v;
    v.rdy = rdy; v.redir = 1'b0; v.rpc = 16'h0000;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr;
    v.ifpc = ifpc; v.pc2 = pc2; v.hlt = hlt;
    return v;
  endfunction

  initial begin
    mem[16'h0000] = 16'h2001;
    mem[16'h0002] = 16'h5810;
    mem[16'h0004] = 16'h1234;
    mem[16'h0006] = 16'h0000;
    mem[16'h0020] = 16'h4444;
    mem[16'h0040] = 16'h0000;
    mem[16'hFFFE] = 16'h3000;

    // each row: inputs for one cycle, outputs expected in the following cycle
    vecs[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h2001, 16'h0000, 16'h0002, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 16'h0002, 1'b0, 16'h2001, 16'h0000, 16'h0002, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 16'h0002, 1'b0, 16'h2001, 16'h0000, 16'h0002, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 16'h0002, 1'b1, 16'h5810, 16'h0002, 16'h0004, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 16'h0004, 1'b0, 16'h5810, 16'h0002, 16'h0004, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 16'h0004, 1'b0, 16'h5810, 16'h0002, 16'h0004, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 16'h0004, 1'b1, 16'h1234, 16'h0004, 16'h0006, 1'b0);
    for (int i = 8; i <= 12; i++) vecs[i] = vecs[7];
    vecs[13] = mk(1'b1, 1'b1, 16'h0006, 1'b0, 16'h1234, 16'h0004, 16'h0006, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 16'h0006, 1'b0, 16'h1234, 16'h0004, 16'h0006, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 16'h0006, 1'b1, 16'h0000, 16'h0006, 16'h0008, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 16'h0008, 1'b0, 16'h0000, 16'h0006, 16'h0008, 1'b1);

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b0;
    tick(); tick();
    chk_reset_values("reset");

    rst_n = 1'b1;
    #1;
    chk("first_req",  {15'h0, imem_req}, 16'h0001);
    chk("first_addr", imem_addr,         16'h0000);

    for (int i = 0; i < NVEC; i++) begin
      id_ready    = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      tick();
      chk($sformatf("v%0d_req", i),    {15'h0, imem_req}, {15'h0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),   imem_addr,         vecs[i].addr);
      chk($sformatf("v%0d_valid", i),  {15'h0, if_valid}, {15'h0, vecs[i].valid});
      chk($sformatf("v%0d_instr", i),  instruction,       vecs[i].instr);
      chk($sformatf("v%0d_if_pc", i),  if_pc,             vecs[i].ifpc);
      chk($sformatf("v%0d_pc2", i),    pc_plus2,          vecs[i].pc2);
      chk($sformatf("v%0d_halted", i), {15'h0, halted},   {15'h0, vecs[i].hlt});
    end

    // halted: no requests for 20 cycles
    id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_no_req", {15'h0, imem_req}, 16'h0000);
      chk("halt_flag",   {15'h0, halted},   16'h0001);
    end

    // leave HALT by redirect; memory latency 4 for the next request
    mem_lat = 4;
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    chk("unhalt_req",    {15'h0, imem_req}, 16'h0001);
    chk("unhalt_addr",   imem_addr,         16'h0010);
    chk("unhalt_halted", {15'h0, halted},   16'h0000);
    tick();
    tick();
    chk("wait_state", {13'h0, dbg_state}, {13'h0, ST_WAIT});

    // redirect in WAIT two cycles after the request, bit 0 of target dropped
    redirect = 1'b1; redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
    mem_lat = 1;
    chk("drain_state", {13'h0, dbg_state}, {13'h0, ST_DRAIN});
    chk("drain_req",   {15'h0, imem_req},  16'h0000);
    chk("drain_valid", {15'h0, if_valid},  16'h0000);
    tick();
    chk("drain2_state", {13'h0, dbg_state}, {13'h0, ST_DRAIN});
    chk("drain2_valid", {15'h0, if_valid},  16'h0000);
    tick();
    chk("post_drain_req",   {15'h0, imem_req}, 16'h0001);
    chk("post_drain_addr",  imem_addr,         16'h0040);
    chk("post_drain_valid", {15'h0, if_valid}, 16'h0000);
    tick();
    tick();
    chk("halt_word_valid", {15'h0, if_valid}, 16'h0001);
    chk("halt_word_instr", instruction,       16'h0000);
    chk("halt_word_if_pc", if_pc,             16'h0040);
    chk("halt_word_pc2",   pc_plus2,          16'h0042);

    // redirect together with handshake on a HALT word
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    chk("rh_state",  {13'h0, dbg_state}, {13'h0, ST_FETCH});
    chk("rh_req",    {15'h0, imem_req},  16'h0001);
    chk("rh_addr",   imem_addr,          16'h0020);
    chk("rh_valid",  {15'h0, if_valid},  16'h0000);
    chk("rh_halted", {15'h0, halted},    16'h0000);

    // redirect in FETCH: the issued request is drained
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    chk("fr_state", {13'h0, dbg_state}, {13'h0, ST_DRAIN});
    chk("fr_req",   {15'h0, imem_req},  16'h0000);
    tick();
    chk("fr_req2",   {15'h0, imem_req}, 16'h0001);
    chk("fr_addr2",  imem_addr,         16'hFFFE);
    chk("fr_valid2", {15'h0, if_valid}, 16'h0000);

    // PC wrap at the top of memory
    tick();
    tick();
    chk("wrap_valid", {15'h0, if_valid}, 16'h0001);
    chk("wrap_instr", instruction,       16'h3000);
    chk("wrap_if_pc", if_pc,             16'hFFFE);
    chk("wrap_pc2",   pc_plus2,          16'h0000);
    tick();
    chk("wrap_req",  {15'h0, imem_req}, 16'h0001);
    chk("wrap_addr", imem_addr,         16'h0000);
    tick();
    chk("wrap_wait", {13'h0, dbg_state}, {13'h0, ST_WAIT});

    // reset asserted while waiting on memory
    rst_n = 1'b0;
    tick();
    chk_reset_values("midrst");
    rst_n = 1'b1;
    #1;
    chk("midrst_req_after",  {15'h0, imem_req}, 16'h0001);
    chk("midrst_addr_after", imem_addr,         16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 16-bit WISC pipeline; it is the producer side of the IF/ID interface that the decode stage consumes. It holds the PC, issues one request at a time to a variable-latency instruction memory, and presents each fetched word with its PC+2 to decode under a valid/ready handshake. It also handles branch/jump redirects, discards stale responses, and stops fetching after a HALT has been handed to decode.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  16  request address (current PC); meaningful only while imem_req=1.
- imem_rdata  in  16  instruction word; valid when imem_done=1.
- imem_done  in  1  response strobe; arrives ≥1 cycle after imem_req.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  16  new PC; bit 0 ignored (forced 0).
- id_ready  in  1  decode accepts the presented instruction this cycle.
- if_valid  out  1  instruction/if_pc/pc_plus2 are valid.
- instruction  out  16  fetched word to decode.
- if_pc  out  16  address of the presented instruction.
- pc_plus2  out  16  if_pc + 2, mod 2^16.
- halted  out  1  HALT accepted by decode; no further requests.

## Operation
- States: FETCH, WAIT, FULL, DRAIN, HALT.
- FETCH: imem_req=1, imem_addr=pc; next state WAIT. Only one outstanding request ever.
- WAIT: on imem_done, register imem_rdata into instruction, if_pc<=pc, pc_plus2<=pc+2, if_valid<=1; go FULL.
- FULL: if_valid=1 and outputs held stable until id_ready=1. On handshake: pc<=pc+2, if_valid<=0; if instruction[15:11]==5'b00000 (HALT) go HALT, else go FETCH.
- HALT: halted=1, imem_req=0, if_valid=0; imem_done ignored. Leaves only on redirect or reset.
- Redirect (any state, priority over handshake and imem_done in the same cycle): pc<={redirect_pc[15:1],1'b0}, if_valid<=0, halted<=0. From WAIT with no imem_done that cycle -> DRAIN; from WAIT with imem_done that cycle -> FETCH (response discarded); from FETCH -> DRAIN (request just issued is outstanding); from FULL/DRAIN/HALT -> FETCH, except DRAIN without imem_done stays DRAIN.
- DRAIN: wait for the stale imem_done, discard its data, go FETCH. Further redirects while in DRAIN only overwrite pc.
- PC arithmetic: 16-bit, pc+2 wraps 16'hFFFE -> 16'h0000 with no flag.
- imem_done in FETCH, FULL or HALT: ignored (protocol violation, not a state change).

## Timing
- Reset values (cycle after rst_n sampled low): state FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, instruction=16'h0800 (NOP), if_pc=RESET_PC, pc_plus2=RESET_PC+2, halted=0.
- Reset mid-operation discards all state; instruction memory shares rst_n, so no pre-reset response arrives after reset.
- First imem_req in the first cycle rst_n is sampled high.
- Memory latency L (imem_done L cycles after req, L≥1): if_valid rises L+1 cycles after req.
- With L=1 and id_ready tied high: one instruction per 3 cycles (req, done, present).
- Redirect latency: imem_req to redirect_pc in the next cycle when no request outstanding; otherwise the cycle after the stale imem_done.
- if_valid drops the cycle after handshake or redirect; outputs never change while if_valid=1 and id_ready=0.

## Test plan
- Reset, RESET_PC=0, L=1, memory returns 16'h2001 at 0, 16'h5810 at 2, id_ready=1 -> imem_addr 0,2,4 on req pulses every 3 cycles; instruction 16'h2001 with pc_plus2=16'h0002, then 16'h5810 with pc_plus2=16'h0004.
- Backpressure: id_ready=0 for 5 cycles with if_valid=1 -> instruction/if_pc constant, no imem_req; id_ready=1 -> next req to if_pc+2 the following cycle.
- Redirect in WAIT, L=4: redirect_pc=16'h0041 two cycles after req -> stale done discarded, if_valid stays 0, next imem_addr=16'h0040.
- Redirect and id_ready same cycle in FULL -> no pc+2 advance, next imem_addr=redirect_pc; HALT in instruction not honoured.
- HALT 16'h0000 at 16'h0006 accepted -> halted=1 next cycle, no further imem_req for 20 cycles; redirect_pc=16'h0010 -> halted=0, req to 16'h0010.
- Wrap: redirect_pc=16'hFFFE, instruction accepted -> pc_plus2=16'h0000, next imem_addr=16'h0000; assert rst_n=0 in WAIT -> all outputs at reset values next cycle.
